// File: rtl/mac_feeder.sv
// Streams activation/weight pairs from two synchronous-read buffers into a mac unit and
// captures the final sum per neuron. Optional threshold/spike output: MAC_FEEDER_THRESH_EN.
module mac_feeder #(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_inputs,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] act_rdata,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [DATA_W-1:0] mac_data,
  output logic [DATA_W-1:0] mac_weight,
  output logic              mac_valid,
  output logic              mac_reset,
  input  logic [ACC_W-1:0]  mac_out,
  input  logic              mac_out_valid,
`ifdef MAC_FEEDER_THRESH_EN
  input  logic [ACC_W-1:0]  threshold,
  output logic              spike,
`endif
  output logic [ACC_W-1:0]  result,
  output logic              result_valid
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(N_INPUTS);

  state_t              state, state_nx;
  logic [ADDR_W:0]     n_lat, n_lat_nx;
  logic [ADDR_W:0]     beat, beat_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic                rd_en_nx, mac_valid_nx, mac_reset_nx;
  logic                busy_nx, done_nx, result_valid_nx;
  logic [ACC_W-1:0]    result_nx;
  logic [ADDR_W:0]     n_clamp, beat_p1, beat_p2;
  logic                spike_nx;
  logic [ACC_W-1:0]    thresh_lat, thresh_lat_nx;

  // Operands come straight from the buffer read ports; the registered mac_valid lines them up.
  assign mac_data   = act_rdata;
  assign mac_weight = w_rdata;
  assign act_addr   = addr;
  assign w_addr     = addr;

  assign n_clamp = (num_inputs > N_MAX) ? N_MAX : num_inputs;
  assign beat_p1 = beat + (ADDR_W+1)'(1);
  assign beat_p2 = beat + (ADDR_W+1)'(2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      n_lat        <= '0;
      beat         <= '0;
      addr         <= '0;
      buf_rd_en    <= 1'b0;
      mac_valid    <= 1'b0;
      mac_reset    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      thresh_lat   <= '0;
    end else begin
      state        <= state_nx;
      n_lat        <= n_lat_nx;
      beat         <= beat_nx;
      addr         <= addr_nx;
      buf_rd_en    <= rd_en_nx;
      mac_valid    <= mac_valid_nx;
      mac_reset    <= mac_reset_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      result_valid <= result_valid_nx;
      result       <= result_nx;
      thresh_lat   <= thresh_lat_nx;
    end
  end

`ifdef MAC_FEEDER_THRESH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) spike <= 1'b0;
    else          spike <= spike_nx;
  end
`endif

  // All outputs are registered: this block computes their values for the next cycle.
  always_comb begin
    state_nx        = state;
    n_lat_nx        = n_lat;
    beat_nx         = beat;
    addr_nx         = addr;
    rd_en_nx        = 1'b0;
    mac_valid_nx    = 1'b0;
    mac_reset_nx    = 1'b0;
    busy_nx         = busy;
    done_nx         = 1'b0;
    result_valid_nx = 1'b0;
    result_nx       = result;
    spike_nx        = 1'b0;
    thresh_lat_nx   = thresh_lat;
    case (state)
      IDLE: begin
        if (start) begin
          n_lat_nx = n_clamp;
          busy_nx  = 1'b1;
`ifdef MAC_FEEDER_THRESH_EN
          thresh_lat_nx = threshold;
`endif
          if (n_clamp == '0) begin
            state_nx        = DONE;
            done_nx         = 1'b1;
            result_valid_nx = 1'b1;
            result_nx       = '0;
`ifdef MAC_FEEDER_THRESH_EN
            spike_nx        = (threshold == '0);
`endif
          end else begin
            state_nx     = CLEAR;
            mac_reset_nx = 1'b1;
            rd_en_nx     = 1'b1;
            addr_nx      = '0;
          end
        end
      end
      CLEAR: begin
        state_nx     = STREAM;
        beat_nx      = '0;
        mac_valid_nx = 1'b1;
        rd_en_nx     = (n_lat > (ADDR_W+1)'(1));
        addr_nx      = (ADDR_W)'(1);
      end
      STREAM: begin
        // The address two beats ahead is issued so read data arrives with its beat.
        if (beat_p1 < n_lat) begin
          beat_nx      = beat_p1;
          mac_valid_nx = 1'b1;
          rd_en_nx     = (beat_p2 < n_lat);
          addr_nx      = beat_p2[ADDR_W-1:0];
        end else begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (mac_out_valid) begin
          state_nx        = DONE;
          done_nx         = 1'b1;
          result_valid_nx = 1'b1;
          result_nx       = mac_out;
          spike_nx        = (mac_out >= thresh_lat);
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized self-checking bench for mac_feeder: buffer and mac models drive the DUT, and a
// per-cycle schedule model derived from start time and beat count checks every output.
module tb_mac_feeder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  num_inputs;
  logic        busy, done, buf_rd_en, mac_valid, mac_reset, result_valid;
  logic [3:0]  act_addr, w_addr;
  logic [7:0]  act_rdata, w_rdata, mac_data, mac_weight;
  logic [15:0] mac_out, result;
  logic        mac_out_valid;
`ifdef MAC_FEEDER_THRESH_EN
  logic [15:0] threshold;
  logic        spike;
`endif

  mac_feeder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_inputs(num_inputs),
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en),
    .act_addr(act_addr), .w_addr(w_addr),
    .act_rdata(act_rdata), .w_rdata(w_rdata),
    .mac_data(mac_data), .mac_weight(mac_weight),
    .mac_valid(mac_valid), .mac_reset(mac_reset),
    .mac_out(mac_out), .mac_out_valid(mac_out_valid),
`ifdef MAC_FEEDER_THRESH_EN
    .threshold(threshold), .spike(spike),
`endif
    .result(result), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] actMem [16];
  logic [7:0] wMem [16];
  logic [7:0] actQ, wQ;
  logic [15:0] acc;
  logic        accValid;

  // Model state: the current neuron is fully described by its start cycle and beat count.
  bit          txValid = 0;
  int          t0 = 0;
  int          expN = 0;
  logic [15:0] expSum = '0;
  logic [15:0] expThr = '0;
  logic [15:0] expResult = '0;
  int          doneRelSeen = -1;
  int          beatCount = 0;
  bit          spikeSeen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read buffers
  always @(posedge clk) begin
    if (buf_rd_en) begin
      actQ <= actMem[act_addr];
      wQ   <= wMem[w_addr];
    end
  end
  assign act_rdata = actQ;
  assign w_rdata   = wQ;

  // Behavioural mac: clear on reset, accumulate on valid, outValid one cycle behind valid
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      accValid <= 1'b0;
    end else begin
      if (mac_reset)      acc <= '0;
      else if (mac_valid) acc <= acc + 16'(mac_data) * 16'(mac_weight);
      accValid <= mac_valid && !mac_reset;
    end
  end
  assign mac_out       = acc;
  assign mac_out_valid = accValid;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Compare process: every cycle, outputs against the schedule implied by t0 and expN.
  always @(negedge clk) begin
    int r, dr;
    bit eBusy, eDone, eRd, eMv, eMr, eSpike;
    eBusy = 0; eDone = 0; eRd = 0; eMv = 0; eMr = 0; eSpike = 0;
    r = 0;
    if (!reset_n) begin
      expResult = '0;
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_rd_en", 32'(buf_rd_en), 0);
      checkOutput("rst_mac_valid", 32'(mac_valid), 0);
      checkOutput("rst_mac_reset", 32'(mac_reset), 0);
      checkOutput("rst_result_valid", 32'(result_valid), 0);
      checkOutput("rst_act_addr", 32'(act_addr), 0);
      checkOutput("rst_w_addr", 32'(w_addr), 0);
      checkOutput("rst_result", 32'(result), 0);
    end else begin
      if (txValid) begin
        r  = cyc - t0;
        dr = (expN == 0) ? 1 : expN + 3;
        if (r == dr) begin
          expResult = expSum;
          eDone     = 1;
          eSpike    = (expSum >= expThr);
        end
        eBusy = (r >= 1 && r <= dr);
        if (expN > 0) begin
          eMr = (r == 1);
          eRd = (r >= 1 && r <= expN);
          eMv = (r >= 2 && r <= expN + 1);
        end
      end
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("result_valid", 32'(result_valid), 32'(eDone));
      checkOutput("buf_rd_en", 32'(buf_rd_en), 32'(eRd));
      checkOutput("mac_valid", 32'(mac_valid), 32'(eMv));
      checkOutput("mac_reset", 32'(mac_reset), 32'(eMr));
      checkOutput("result", 32'(result), 32'(expResult));
      if (eRd) begin
        checkOutput("act_addr", 32'(act_addr), 32'(r - 1));
        checkOutput("w_addr", 32'(w_addr), 32'(r - 1));
      end
      if (eMv) begin
        checkOutput("mac_data", 32'(mac_data), 32'(actMem[r - 2]));
        checkOutput("mac_weight", 32'(mac_weight), 32'(wMem[r - 2]));
      end
`ifdef MAC_FEEDER_THRESH_EN
      checkOutput("spike", 32'(spike), 32'(eSpike));
      if (done) spikeSeen = spike;
`endif
      if (mac_valid) beatCount++;
      if (done) doneRelSeen = r;
    end
  end

  task automatic applyStimulus(input int n, input logic [15:0] thr);
    int eff, s;
    eff = (n > 16) ? 16 : n;
    s = 0;
    for (int k = 0; k < eff; k++) s += int'(actMem[k]) * int'(wMem[k]);
    @(posedge clk); #1;
    start      = 1'b1;
    num_inputs = 5'(n);
`ifdef MAC_FEEDER_THRESH_EN
    threshold  = thr;
`endif
    t0          = cyc;
    expN        = eff;
    expSum      = 16'(s);
    expThr      = thr;
    txValid     = 1;
    doneRelSeen = -1;
    beatCount   = 0;
    @(posedge clk); #1;
    start      = 1'b0;
    num_inputs = 5'($urandom_range(0, 31));
`ifdef MAC_FEEDER_THRESH_EN
    threshold  = 16'($urandom);
`endif
  endtask

  task automatic runNeuron(input int n, input logic [15:0] thr, input bit pulseBusy);
    int dr;
    applyStimulus(n, thr);
    dr = (expN == 0) ? 1 : expN + 3;
    while (cyc < t0 + dr) begin
      @(posedge clk); #1;
      start = (pulseBusy && expN >= 2 && cyc == t0 + 3);
      if (start) num_inputs = 5'($urandom_range(0, 31));
    end
    start = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 16; k++) begin
      actMem[k] = (mode == 1) ? 8'd255 : 8'($urandom);
      wMem[k]   = (mode == 1) ? 8'd255 : 8'($urandom);
    end
  endtask

  initial begin
    int n;
    logic [15:0] thr;
    reset_n    = 1'b0;
    start      = 1'b0;
    num_inputs = '0;
`ifdef MAC_FEEDER_THRESH_EN
    threshold  = '0;
`endif
    fill(0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Three beats {1,2,3}.{4,5,6} = 32, done six cycles after start
    actMem[0] = 8'd1; actMem[1] = 8'd2; actMem[2] = 8'd3;
    wMem[0]   = 8'd4; wMem[1]   = 8'd5; wMem[2]   = 8'd6;
    runNeuron(3, 16'd32, 0);
    checkOutput("caseA_result", 32'(result), 32);
    checkOutput("caseA_done_cycle", 32'(doneRelSeen), 6);
    checkOutput("caseA_beats", 32'(beatCount), 3);
`ifdef MAC_FEEDER_THRESH_EN
    checkOutput("caseA_spike_thr32", 32'(spikeSeen), 1);
    runNeuron(3, 16'd33, 0);
    checkOutput("caseA_spike_thr33", 32'(spikeSeen), 0);
`endif

    // Sixteen beats of 255*255 wrap: 16*65025 mod 65536 = 57360
    fill(1);
    runNeuron(16, 16'd0, 0);
    checkOutput("caseB_result", 32'(result), 57360);
    checkOutput("caseB_done_cycle", 32'(doneRelSeen), 19);

    // Zero beats: immediate done with result 0
    runNeuron(0, 16'd0, 0);
    checkOutput("caseC_result", 32'(result), 0);
    checkOutput("caseC_done_cycle", 32'(doneRelSeen), 1);
    checkOutput("caseC_beats", 32'(beatCount), 0);

    // Over-range count clamps to 16, with a start pulse during streaming
    fill(0);
    runNeuron(20, 16'd0, 1);
    checkOutput("caseD_beats", 32'(beatCount), 16);
    checkOutput("caseD_done_cycle", 32'(doneRelSeen), 19);

    // Asynchronous reset during beat 2 of a five-beat neuron
    fill(0);
    applyStimulus(5, 16'd0);
    while (cyc < t0 + 4) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    txValid = 0;
    #1;
    checkOutput("midrst_mac_valid", 32'(mac_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_rd_en", 32'(buf_rd_en), 0);
    checkOutput("midrst_result", 32'(result), 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    actMem[0] = 8'd1; actMem[1] = 8'd1;
    wMem[0]   = 8'd7; wMem[1]   = 8'd9;
    runNeuron(2, 16'd16, 0);
    checkOutput("caseE_result", 32'(result), 16);
    checkOutput("caseE_done_cycle", 32'(doneRelSeen), 5);

    // Randomized neurons, some back-to-back, some with ignored starts while busy
    for (int i = 0; i < 40; i++) begin
      fill(0);
      n = $urandom_range(0, 20);
      thr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        int s;
        s = 0;
        for (int k = 0; k < ((n > 16) ? 16 : n); k++) s += int'(actMem[k]) * int'(wMem[k]);
        thr = 16'(s) + 16'($urandom_range(0, 2)) - 16'd1;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      runNeuron(n, thr, bit'($urandom_range(0, 1)));
      checkOutput("rand_result", 32'(result), 32'(expSum));
      checkOutput("rand_beats", 32'(beatCount), 32'(expN));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
